// File: rtl/led_switch_ctrl_if.sv
// Front-panel pin bundle: four raw push switches in, four LED drives out.
// The board side (master) drives the switches; the controller (slave) drives the LEDs.
interface led_switch_ctrl_if;
    logic i_Switch_1;
    logic i_Switch_2;
    logic i_Switch_3;
    logic i_Switch_4;
    logic o_LED_1;
    logic o_LED_2;
    logic o_LED_3;
    logic o_LED_4;

    modport master (
        output i_Switch_1, i_Switch_2, i_Switch_3, i_Switch_4,
        input  o_LED_1, o_LED_2, o_LED_3, o_LED_4
    );

    modport slave (
        input  i_Switch_1, i_Switch_2, i_Switch_3, i_Switch_4,
        output o_LED_1, o_LED_2, o_LED_3, o_LED_4
    );
endinterface

// File: rtl/led_switch_ctrl.sv
// Go Board front-panel controller: debounced switches select the mode, speed and
// pause state of an animated LED pattern (off / blink / chase / count).
module led_switch_ctrl #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int TICK_BASE       = 3125000
) (
    input  logic             i_Clk,
    input  logic             i_Rst_L,
    led_switch_ctrl_if.slave pins
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int PW = $clog2(TICK_BASE + 1);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_BLINK = 2'd1,
        MODE_CHASE = 2'd2,
        MODE_COUNT = 2'd3
    } mode_e;

    logic [3:0]         raw;
    logic [3:0]         sync1_q, sync1_d, sync2_q, sync2_d;
    logic [3:0]         deb_q, deb_d, deb_prev_q, deb_prev_d;
    logic [3:0][DW-1:0] cnt_q, cnt_d;
    logic [3:0]         press;
    mode_e              mode_q, mode_d;
    logic [1:0]         speed_q, speed_d;
    logic               pause_q, pause_d;
    logic [PW-1:0]      presc_q, presc_d, period_last;
    logic               step;
    logic               blink_off_q, blink_off_d;
    logic [3:0]         chase_q, chase_d, count_q, count_d;
    logic [3:0]         pattern, led_q, led_d;

    // Bit i of every switch vector belongs to i_Switch_(i+1).
    assign raw = {pins.i_Switch_4, pins.i_Switch_3, pins.i_Switch_2, pins.i_Switch_1};

    always_comb begin
        sync1_d    = raw;
        sync2_d    = sync1_q;
        deb_prev_d = deb_q;
        deb_d      = deb_q;
        cnt_d      = cnt_q;
        for (int i = 0; i < 4; i++) begin
            if (sync2_q[i] == deb_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == DEB_LAST) begin
                deb_d[i] = sync2_q[i];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + DW'(1);
            end
        end
        press = deb_q & ~deb_prev_q;
    end

    always_comb begin
        mode_d      = mode_q;
        speed_d     = speed_q;
        pause_d     = pause_q ^ press[3];
        presc_d     = presc_q;
        blink_off_d = blink_off_q;
        chase_d     = chase_q;
        count_d     = count_q;
        period_last = PW'((TICK_BASE >> speed_q) - 1);
        step        = !pause_q && (presc_q == period_last);

        if (press[0]) begin
            case (mode_q)
                MODE_OFF:   mode_d = MODE_BLINK;
                MODE_BLINK: mode_d = MODE_CHASE;
                MODE_CHASE: mode_d = MODE_COUNT;
                default:    mode_d = MODE_OFF;
            endcase
        end

        // Opposing speed presses in the same cycle cancel out.
        if (press[1] && !press[2] && speed_q != 2'd3) begin
            speed_d = speed_q + 2'd1;
        end else if (press[2] && !press[1] && speed_q != 2'd0) begin
            speed_d = speed_q - 2'd1;
        end

        if (press[0] || speed_d != speed_q) begin
            presc_d = '0;
        end else if (!pause_q) begin
            presc_d = step ? '0 : presc_q + PW'(1);
        end

        // A new mode always restarts from its first frame; blink starts lit so the change is visible.
        if (press[0]) begin
            blink_off_d = 1'b0;
            chase_d     = 4'b1000;
            count_d     = 4'h0;
        end else if (step) begin
            case (mode_q)
                MODE_BLINK: blink_off_d = ~blink_off_q;
                MODE_CHASE: chase_d     = {chase_q[0], chase_q[3:1]};
                MODE_COUNT: count_d     = count_q + 4'h1;
                default:    ;
            endcase
        end

        case (mode_q)
            MODE_BLINK: pattern = {4{~blink_off_q}};
            MODE_CHASE: pattern = chase_q;
            MODE_COUNT: pattern = count_q;
            default:    pattern = 4'b0000;
        endcase
        led_d = pattern;
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            deb_q       <= '0;
            deb_prev_q  <= '0;
            cnt_q       <= '0;
            mode_q      <= MODE_OFF;
            speed_q     <= 2'd0;
            pause_q     <= 1'b0;
            presc_q     <= '0;
            blink_off_q <= 1'b0;
            chase_q     <= 4'b0000;
            count_q     <= 4'h0;
            led_q       <= 4'b0000;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            deb_q       <= deb_d;
            deb_prev_q  <= deb_prev_d;
            cnt_q       <= cnt_d;
            mode_q      <= mode_d;
            speed_q     <= speed_d;
            pause_q     <= pause_d;
            presc_q     <= presc_d;
            blink_off_q <= blink_off_d;
            chase_q     <= chase_d;
            count_q     <= count_d;
            led_q       <= led_d;
        end
    end

    assign pins.o_LED_1 = led_q[3];
    assign pins.o_LED_2 = led_q[2];
    assign pins.o_LED_3 = led_q[1];
    assign pins.o_LED_4 = led_q[0];
endmodule

// File: tb/tb_led_switch_ctrl.sv
// Bench for led_switch_ctrl: a cycle-level behavioural model of the front panel is
// compared on every clock, plus hand-computed checks of the key sequences.
module tb_led_switch_ctrl;
    localparam int TB_DEB  = 4;
    localparam int TB_TICK = 16;

    logic clk;
    logic rst_n;
    int   cmp_n;
    int   fail_n;

    led_switch_ctrl_if pins();

    led_switch_ctrl #(
        .DEBOUNCE_CYCLES(TB_DEB),
        .TICK_BASE      (TB_TICK)
    ) dut (
        .i_Clk  (clk),
        .i_Rst_L(rst_n),
        .pins   (pins)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state: plain integers describing what the panel is showing and why.
    int         m_mode;
    int         m_speed;
    bit         m_pause;
    int         m_presc;
    bit         m_blink_on;
    int         m_chase_pos;
    int         m_count;
    logic [3:0] m_deb;
    logic [3:0] m_pend;
    logic [3:0] m_hist [0:TB_DEB+1];
    logic [3:0] exp_led;

    function automatic logic [3:0] leds();
        return {pins.o_LED_1, pins.o_LED_2, pins.o_LED_3, pins.o_LED_4};
    endfunction

    function automatic logic [3:0] model_pattern();
        case (m_mode)
            1:       return m_blink_on ? 4'hF : 4'h0;
            2:       return 4'(8 >> m_chase_pos);
            3:       return 4'(m_count);
            default: return 4'h0;
        endcase
    endfunction

    task automatic model_reset();
        m_mode = 0; m_speed = 0; m_pause = 0; m_presc = 0;
        m_blink_on = 0; m_chase_pos = 0; m_count = 0;
        m_deb = '0; m_pend = '0; exp_led = '0;
        for (int j = 0; j <= TB_DEB + 1; j++) m_hist[j] = '0;
    endtask

    // A switch is accepted once its raw level, seen two clocks late, has
    // differed from the accepted level for TB_DEB consecutive samples.
    task automatic model_step();
        logic [3:0] new_led;
        bit         step;
        int         old_speed;
        bit         old_pause;
        bit         all_diff;
        new_led   = model_pattern();
        step      = !m_pause && (m_presc == (TB_TICK >> m_speed) - 1);
        old_speed = m_speed;
        old_pause = m_pause;
        if (m_pend[1] && !m_pend[2]) m_speed = (m_speed == 3) ? 3 : m_speed + 1;
        else if (m_pend[2] && !m_pend[1]) m_speed = (m_speed == 0) ? 0 : m_speed - 1;
        if (m_pend[3]) m_pause = !m_pause;
        if (m_pend[0]) begin
            m_mode = (m_mode + 1) % 4;
            m_presc = 0; m_blink_on = 1; m_chase_pos = 0; m_count = 0;
        end else begin
            if (m_speed != old_speed) m_presc = 0;
            else if (!old_pause) m_presc = step ? 0 : m_presc + 1;
            if (step) begin
                if (m_mode == 1) m_blink_on = !m_blink_on;
                if (m_mode == 2) m_chase_pos = (m_chase_pos + 1) % 4;
                if (m_mode == 3) m_count = (m_count + 1) % 16;
            end
        end
        for (int j = TB_DEB + 1; j > 0; j--) m_hist[j] = m_hist[j-1];
        m_hist[0] = {pins.i_Switch_4, pins.i_Switch_3, pins.i_Switch_2, pins.i_Switch_1};
        for (int i = 0; i < 4; i++) begin
            all_diff = 1;
            for (int j = 2; j <= TB_DEB + 1; j++)
                if (m_hist[j][i] == m_deb[i]) all_diff = 0;
            if (all_diff) m_deb[i] = ~m_deb[i];
            m_pend[i] = all_diff && m_deb[i];
        end
        exp_led = new_led;
    endtask

    task automatic compare_model();
        logic [3:0] got;
        got = leds();
        cmp_n++;
        if (got !== exp_led) begin
            fail_n++;
            $display("[TB] FAIL model_led @%0t: got %b expected %b", $time, got, exp_led);
        end
    endtask

    task automatic check_output(input string name, input int actual, input int expected);
        cmp_n++;
        if (actual != expected) begin
            fail_n++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input logic [3:0] sw, input int cycles);
        {pins.i_Switch_4, pins.i_Switch_3, pins.i_Switch_2, pins.i_Switch_1} = sw;
        for (int n = 0; n < cycles; n++) begin
            @(posedge clk);
            if (!rst_n) model_reset();
            else model_step();
            @(negedge clk);
            compare_model();
        end
    endtask

    task automatic press(input int idx);
        apply_stimulus(4'(1 << idx), 6);
        apply_stimulus(4'b0000, 6);
    endtask

    task automatic next_change(output int val);
        logic [3:0] prev;
        prev = leds();
        val  = -1;
        for (int n = 0; n < 100; n++) begin
            apply_stimulus(4'b0000, 1);
            if (leds() != prev) begin
                val = int'(leds());
                return;
            end
        end
    endtask

    task automatic measure_period(output int p);
        int v;
        logic [3:0] prev;
        p = -1;
        next_change(v);
        if (v < 0) return;
        prev = leds();
        for (int n = 1; n <= 100; n++) begin
            apply_stimulus(4'b0000, 1);
            if (leds() != prev) begin
                p = n;
                return;
            end
        end
    endtask

    task automatic wait_for(input logic [3:0] val, output bit found);
        found = 0;
        for (int n = 0; n < 200; n++) begin
            if (leds() == val) begin
                found = 1;
                return;
            end
            apply_stimulus(4'b0000, 1);
        end
    endtask

    initial begin
        int  v;
        int  bad;
        bit  found;
        cmp_n  = 0;
        fail_n = 0;
        rst_n  = 1'b0;
        {pins.i_Switch_4, pins.i_Switch_3, pins.i_Switch_2, pins.i_Switch_1} = 4'b0000;
        model_reset();
        apply_stimulus(4'b0000, 3);
        check_output("reset_leds", int'(leds()), 0);
        rst_n = 1'b1;
        apply_stimulus(4'b0000, 2);

        // Three-clock glitch on Switch_1 must not register.
        apply_stimulus(4'b0001, 3);
        apply_stimulus(4'b0000, 20);
        check_output("glitch_leds", int'(leds()), 0);

        // Clean press: BLINK appears exactly 8 edges after the raw edge.
        apply_stimulus(4'b0001, 7);
        check_output("blink_edge7", int'(leds()), 4'b0000);
        apply_stimulus(4'b0001, 1);
        check_output("blink_edge8", int'(leds()), 4'b1111);
        apply_stimulus(4'b0000, 6);
        measure_period(v);
        check_output("blink_period", v, 16);

        press(0);
        wait_for(4'b1000, found);
        check_output("chase_start", int'(found), 1);
        next_change(v); check_output("chase_1", v, 4'b0100);
        next_change(v); check_output("chase_2", v, 4'b0010);
        next_change(v); check_output("chase_3", v, 4'b0001);
        next_change(v); check_output("chase_4", v, 4'b1000);

        for (int k = 0; k < 5; k++) press(1);
        measure_period(v);
        check_output("period_s3", v, 2);
        for (int k = 0; k < 5; k++) press(2);
        measure_period(v);
        check_output("period_s0", v, 16);
        apply_stimulus(4'b0110, 6);
        apply_stimulus(4'b0000, 6);
        measure_period(v);
        check_output("period_both", v, 16);

        press(0);
        check_output("count_start", int'(leds()), 0);
        for (int k = 1; k <= 16; k++) begin
            next_change(v);
            check_output("count_step", v, k % 16);
        end

        wait_for(4'b0101, found);
        check_output("count_at5", int'(found), 1);
        press(3);
        bad = 0;
        for (int n = 0; n < 200; n++) begin
            apply_stimulus(4'b0000, 1);
            if (leds() != 4'b0101) bad++;
        end
        check_output("pause_hold", bad, 0);
        press(3);
        next_change(v);
        check_output("resume_next", v, 4'b0110);

        press(3);
        press(0);
        apply_stimulus(4'b0000, 30);
        check_output("paused_off", int'(leds()), 0);
        press(0);
        bad = 0;
        for (int n = 0; n < 50; n++) begin
            apply_stimulus(4'b0000, 1);
            if (leds() != 4'b1111) bad++;
        end
        check_output("paused_blink_hold", bad, 0);
        press(3);
        press(0);
        wait_for(4'b0100, found);
        check_output("chase_again", int'(found), 1);

        // Asynchronous reset between edges, with Switch_1 held through release.
        #2;
        rst_n = 1'b0;
        pins.i_Switch_1 = 1'b1;
        #1;
        check_output("async_reset", int'(leds()), 0);
        model_reset();
        apply_stimulus(4'b0001, 3);
        rst_n = 1'b1;
        apply_stimulus(4'b0001, 7);
        check_output("held_edge7", int'(leds()), 4'b0000);
        apply_stimulus(4'b0001, 1);
        check_output("held_edge8", int'(leds()), 4'b1111);
        apply_stimulus(4'b0000, 6);
        measure_period(v);
        check_output("held_blink_period", v, 16);
        apply_stimulus(4'b0000, 40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, fail_n);
        $finish;
    end
endmodule
